dmem_stall_ctrl: RTL and testbench
==================================

// Module: dmem_stall_ctrl
// PURPOSE
//   Data-memory controller directly downstream of the single-cycle datapath.
//   - Consumes AluOut as the address, WriteData as store data, and MemRead/MemWrite from the controller.
//   - Returns ReadData to the result mux.
//   - Models a slow memory with a fixed multi-cycle latency and asserts Stall so the PC register and
//     register-file write hold until the access completes.
//   - Flags misaligned word accesses instead of performing them.
// PARAMETERS
//   DEPTH_WORDS  256  RAM size in 32-bit words; power of two.
//   LATENCY      2    stall cycles per aligned access; >= 1.
// PORTS
//   CLK        in   1   clock, rising edge.
//   Reset      in   1   synchronous, active-high.
//   MemRead    in   1   load request from the current instruction.
//   MemWrite   in   1   store request from the current instruction.
//   Addr       in   32  byte address (datapath AluOut).
//   WriteData  in   32  store data (datapath WriteData).
//   ReadData   out  32  load data (to the datapath resmux).
//   Stall      out  1   1 = hold PC and suppress RegWrite this cycle.
//   AddrErr    out  1   one-cycle pulse: misaligned access rejected.
// BEHAVIOUR
//   - Single clock CLK. Reset is synchronous and active-high. On Reset, or while Reset is high:
//     state=IDLE, ReadData=0, AddrErr=0, counter=0. Stall is 0 while Reset is high.
//     RAM contents are not cleared.
//   - req = MemRead | MemWrite. Misaligned = Addr[1:0] != 0.
//   - Word index = Addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.
//   - FSM states:
//     - IDLE:
//       - req & aligned: latch Addr, WriteData and op (MemWrite wins if both are set);
//         go WAIT if LATENCY>1, otherwise go DONE. Counter loads LATENCY-1.
//       - req & misaligned: no access; AddrErr=1 on the next cycle only; stay IDLE; no stall.
//       - no req: stay IDLE.
//     - WAIT: counter decrements each cycle. When the counter reaches 1, go DONE on the next edge.
//     - DONE: Stall=0; ReadData is valid. Go IDLE unconditionally. Any req seen in DONE is ignored,
//       because it still belongs to the same instruction.
//   - Stall = (IDLE & req & aligned & !Reset) | (state==WAIT). Stall is combinational, so it is
//     visible in the same cycle as the request. The total stalled cycles per access is exactly LATENCY.
//   - Commit happens on the edge that enters DONE:
//     - Store: RAM[idx] <= latched WriteData.
//     - Load: ReadData <= RAM[idx].
//     - Load and store together: treated as a store; ReadData <= the pre-write word.
//   - ReadData holds its value until the next completed load or Reset. A store does not update ReadData.
//   - Inputs are latched at acceptance. Changes to Addr, WriteData or req during WAIT are ignored.
//   - Reset during WAIT aborts the access; a pending store is not committed.
//   - Timing: request in cycle 0 -> Stall=1 in cycles 0..LATENCY-1 -> DONE in cycle LATENCY ->
//     the datapath advances at the end of cycle LATENCY.
// STRUCTURE
//   - Package dmem_pkg holds:
//     - the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
//     - the word-index width function clog2(DEPTH_WORDS);
//     - the alignment mask constant 2'b00.
//   - One sub-module, ram_sp: single-port synchronous RAM with a write-enable and a registered read,
//     DEPTH_WORDS x 32.
//   - FSM, counter, input latches and error pulse live in this module.
// TESTING (LATENCY=2, DEPTH_WORDS=256)
//   1. Reset, then MemWrite Addr=0x10 WriteData=0xDEADBEEF -> Stall=1 for 2 cycles, then 0;
//      a following MemRead at Addr=0x10 -> ReadData=0xDEADBEEF in its DONE cycle.
//   2. MemRead Addr=0x402 -> no Stall, AddrErr=1 for exactly one cycle, RAM and ReadData unchanged.
//   3. Write 0x11111111 to Addr=0x0, then read Addr=0x400 (wraps to word 0) -> ReadData=0x11111111.
//   4. MemRead=MemWrite=1, Addr=0x20 (old value 0xAAAA5555), WriteData=0x12345678
//      -> ReadData=0xAAAA5555; a later read of 0x20 returns 0x12345678.
//   5. MemWrite Addr=0x30 WriteData=0xCAFEF00D; Reset asserted in the WAIT cycle
//      -> Stall=0 next cycle, state IDLE; a read of 0x30 returns the prior value, not 0xCAFEF00D.
//   6. Back-to-back loads with req held high through DONE -> exactly 2 stall cycles per load
//      and no re-trigger in DONE; the Addr change during WAIT is ignored.

Source files
------------

// File: rtl/dmem_stall_ctrl_pkg.sv
// dmem_pkg: shared constants for the data-memory stall controller.
//   - FSM state encoding (IDLE / WAIT / DONE)
//   - word-alignment mask for byte addresses
//   - clog2 helper used to size the word index and the latency counter
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Low two address bits of an aligned word access
    localparam logic [1:0] ALIGN_OK = 2'b00;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// dmem_stall_ctrl_if: datapath <-> data-memory bus.
//   MemRead/MemWrite  load/store request of the current instruction
//   Addr              byte address (AluOut)
//   WriteData         store data
//   ReadData          load data back to the result mux
//   Stall             hold PC / suppress RegWrite while 1
//   AddrErr           one-cycle pulse for a rejected misaligned access
// master = datapath side, slave = memory controller side.
interface dmem_stall_ctrl_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrErr;

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData, Stall, AddrErr
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData, Stall, AddrErr
    );

endinterface

// File: rtl/dmem_stall_ctrl_ram_sp.sv
// ram_sp: single-port synchronous RAM, DEPTH x 32.
//   clk    clock, rising edge
//   rst    synchronous active-high; clears only the read register
//   we     write enable
//   re     read enable; rdata updates only on an enabled read
//   addr   word index
//   wdata  write data
//   rdata  registered read data; on a simultaneous read and write it
//          returns the word as it was before the write
module ram_sp #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_array[addr];
        end
    end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: data-memory controller with a fixed multi-cycle latency.
//   CLK    clock, rising edge
//   Reset  synchronous, active-high
//   mem    slave side of dmem_stall_ctrl_if (requests in, ReadData/Stall/AddrErr out)
// An aligned request stalls the datapath for exactly LATENCY cycles; the
// RAM access commits on the edge that enters DONE. Misaligned requests are
// rejected with a one-cycle AddrErr pulse and never stall.
module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    dmem_stall_ctrl_if.slave mem
);

    localparam int unsigned   IW       = clog2(DEPTH_WORDS);
    localparam int unsigned   CW       = clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_store;
    logic          lat_load;
    logic          addr_err;

    logic          req;
    logic          aligned;
    logic          accept;
    logic          commit;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          ram_we;
    logic          ram_re;
    logic          unused_addr_bits;

    // Upper address bits are deliberately dropped so accesses wrap
    assign unused_addr_bits = ^mem.Addr[31:IW+2];

    always_comb begin
        req     = mem.MemRead | mem.MemWrite;
        aligned = (mem.Addr[1:0] == ALIGN_OK);
        cur_idx = mem.Addr[IW+1:2];
        accept  = (state == ST_IDLE) & req & aligned;
        // Commit on the edge entering DONE: straight from IDLE when
        // LATENCY==1, otherwise on the last WAIT cycle.
        commit  = !Reset & ((accept & (LATENCY == 1)) |
                            ((state == ST_WAIT) & (cnt == CNT_ONE)));
        // In IDLE the live bus is used (LATENCY==1 commits before anything
        // is latched); in every other state the latched request is used.
        if (state == ST_IDLE) begin
            ram_addr  = cur_idx;
            ram_wdata = mem.WriteData;
            ram_we    = commit & mem.MemWrite;
            ram_re    = commit & mem.MemRead;
        end else begin
            ram_addr  = lat_idx;
            ram_wdata = lat_wdata;
            ram_we    = commit & lat_store;
            ram_re    = commit & lat_load;
        end
    end

    assign mem.Stall    = !Reset & (accept | (state == ST_WAIT));
    assign mem.AddrErr  = addr_err;
    assign mem.ReadData = ram_rdata;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state == ST_IDLE) & req & !aligned;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_idx   <= cur_idx;
                        lat_wdata <= mem.WriteData;
                        lat_store <= mem.MemWrite;
                        lat_load  <= mem.MemRead;
                        cnt       <= CNT_LOAD;
                        state     <= (LATENCY > 1) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ram_sp #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IW)
    ) u_ram (
        .clk   (CLK),
        .rst   (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl with LATENCY=2, DEPTH_WORDS=256.
// Per-cycle vector table checks Stall/AddrErr/ReadData; every accepted
// access pushes the ReadData expected at its DONE cycle into a scoreboard
// queue that a negedge monitor pops when Stall falls outside reset.
module tb_dmem_stall_ctrl;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    dmem_stall_ctrl_if mem ();

    dmem_stall_ctrl #(
        .DEPTH_WORDS (256),
        .LATENCY     (2)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .mem   (mem)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        err;
        logic        push;
        logic [31:0] exp_rd;
        logic        chk;
        logic [31:0] rd_now;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic stall, input logic err,
                       input logic push, input logic [31:0] exp_rd,
                       input logic chk, input logic [31:0] rd_now);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.stall = stall; v.err = err; v.push = push; v.exp_rd = exp_rd;
        v.chk = chk; v.rd_now = rd_now;
        tbl.push_back(v);
    endtask

    // Scoreboard monitor: Stall falling (not due to Reset) marks DONE
    always @(negedge CLK) begin
        if (!Reset && prev_stall && !mem.Stall) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_done: got DONE expected none");
            end else begin
                check("sb_done_rd", mem.ReadData, sb.pop_front());
            end
        end
        prev_stall = mem.Stall;
    end

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        Reset         = rst;
        mem.MemRead   = rd;
        mem.MemWrite  = wr;
        mem.Addr      = addr;
        mem.WriteData = wdata;
    endtask

    // Issue one access, hold it one cycle, count stalled cycles (bounded)
    task automatic timed_access(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd);
        int n;
        @(posedge CLK); #1;
        drive(1'b0, rd, wr, addr, wdata);
        sb.push_back(exp_rd);
        n = 0;
        @(negedge CLK);
        while (mem.Stall === 1'b1 && n < 20) begin
            n++;
            @(posedge CLK); #1;
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge CLK);
        end
        check(name, 32'(n), 32'd2);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        //  rst rd wr addr          wdata         st er  push exp_rd        chk rd_now
        // reset state
        add(1, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(1, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'h0);
        // 1: store then load at 0x10
        add(0, 0, 1, 32'h10,       32'hDEADBEEF, 1, 0,  1, 32'h0,         0, 32'h0);
        add(0, 0, 1, 32'h10,       32'hDEADBEEF, 1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'h0);
        add(0, 1, 0, 32'h10,       32'h0,        1, 0,  1, 32'hDEADBEEF,  0, 32'h0);
        add(0, 1, 0, 32'h10,       32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'hDEADBEEF);
        // 2: misaligned load and misaligned store to word 4 are rejected
        add(0, 1, 0, 32'h402,      32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 1,  0, 32'h0,         1, 32'hDEADBEEF);
        add(0, 0, 1, 32'h13,       32'h0BADBAD0, 0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 1,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'hDEADBEEF);
        add(0, 1, 0, 32'h10,       32'h0,        1, 0,  1, 32'hDEADBEEF,  0, 32'h0);
        add(0, 1, 0, 32'h10,       32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        // 3: write word 0, read it back via wrapped address 0x400
        add(0, 0, 1, 32'h0,        32'h11111111, 1, 0,  1, 32'hDEADBEEF,  0, 32'h0);
        add(0, 0, 1, 32'h0,        32'h11111111, 1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h400,      32'h0,        1, 0,  1, 32'h11111111,  0, 32'h0);
        add(0, 1, 0, 32'h400,      32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        // 4: load+store returns the pre-write word
        add(0, 0, 1, 32'h20,       32'hAAAA5555, 1, 0,  1, 32'h11111111,  0, 32'h0);
        add(0, 0, 1, 32'h20,       32'hAAAA5555, 1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 1, 32'h20,       32'h12345678, 1, 0,  1, 32'hAAAA5555,  0, 32'h0);
        add(0, 1, 1, 32'h20,       32'h12345678, 1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h20,       32'h0,        1, 0,  1, 32'h12345678,  0, 32'h0);
        add(0, 1, 0, 32'h20,       32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        // high address bits ignored: 0xFFFFFC00 -> word 0, 0xFFFFFC20 -> word 8
        add(0, 1, 0, 32'hFFFFFC00, 32'h0,        1, 0,  1, 32'h11111111,  0, 32'h0);
        add(0, 1, 0, 32'hFFFFFC00, 32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'hFFFFFC20, 32'h0,        1, 0,  1, 32'h12345678,  0, 32'h0);
        add(0, 1, 0, 32'hFFFFFC20, 32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        // 5: reset during WAIT aborts a store
        add(0, 0, 1, 32'h30,       32'h01010101, 1, 0,  1, 32'h12345678,  0, 32'h0);
        add(0, 0, 1, 32'h30,       32'h01010101, 1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 1, 32'h30,       32'hCAFEF00D, 1, 0,  0, 32'h0,         0, 32'h0);
        add(1, 0, 1, 32'h30,       32'hCAFEF00D, 0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'h0);
        add(0, 1, 0, 32'h30,       32'h0,        1, 0,  1, 32'h01010101,  0, 32'h0);
        add(0, 1, 0, 32'h30,       32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        // 6: back-to-back loads, req held through DONE, Addr moved in WAIT
        add(0, 1, 0, 32'h10,       32'h0,        1, 0,  1, 32'hDEADBEEF,  0, 32'h0);
        add(0, 1, 0, 32'h0,        32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h20,       32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h20,       32'h0,        1, 0,  1, 32'h12345678,  0, 32'h0);
        add(0, 1, 0, 32'h30,       32'h0,        1, 0,  0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h30,       32'h0,        0, 0,  0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 32'h0,         1, 32'h12345678);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK); #1;
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].push) begin
                sb.push_back(tbl[i].exp_rd);
            end
            @(negedge CLK);
            check($sformatf("row%0d_stall", i), {31'b0, mem.Stall}, {31'b0, tbl[i].stall});
            check($sformatf("row%0d_addrerr", i), {31'b0, mem.AddrErr}, {31'b0, tbl[i].err});
            if (tbl[i].chk) begin
                check($sformatf("row%0d_readdata", i), mem.ReadData, tbl[i].rd_now);
            end
        end

        // Stall length measured directly, request dropped after acceptance
        timed_access("store_stall_cycles", 1'b0, 1'b1, 32'h44, 32'h5A5A5A5A, 32'h12345678);
        timed_access("load_stall_cycles",  1'b1, 1'b0, 32'h44, 32'h0,        32'h5A5A5A5A);

        repeat (3) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
